// File: rtl/xadc_pkg.sv
// xadc_pkg: shared constants and types for the XADC DRP scheduler.
//   - DRP address / data / sample widths
//   - auxiliary-channel result register addresses
//   - transaction FSM state encoding and requester identifiers
package xadc_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 16;
  localparam int SAMPLE_W = 12;
  // Timeout counter width, enough for TIMEOUT up to 1023.
  localparam int CNT_W    = 10;

  localparam logic [ADDR_W-1:0] VAUX4_ADDR  = 7'h14;
  localparam logic [ADDR_W-1:0] VAUX12_ADDR = 7'h1c;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } drp_state_t;

  typedef enum logic {
    SRC_SCAN = 1'b0,
    SRC_HOST = 1'b1
  } drp_src_t;

endpackage

// File: rtl/xadc_drp_master.sv
// xadc_drp_master: runs one DRP read at a time (ISSUE -> WAIT -> STORE).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start, addr   begin a read of addr (accepted in IDLE or STORE)
//   drdy_in       DRP data ready
//   den, daddr    registered DRP enable / address
//   done          combinational: drdy seen in WAIT (data is on do_in now)
//   err           combinational: last WAIT cycle before timeout
//   busy          registered, high while state is not IDLE
//   state         current FSM state, used by the scheduler
module xadc_drp_master
  import xadc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              drdy_in,
  output logic              den,
  output logic [ADDR_W-1:0] daddr,
  output logic              done,
  output logic              err,
  output logic              busy,
  output drp_state_t        state
);

  // cnt_r counts completed WAIT cycles; reaching TIMEOUT-1 here means the
  // timeout pulse lands exactly TIMEOUT cycles after WAIT was entered.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  drp_state_t        state_r;
  drp_state_t        state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              den_r;
  logic              busy_r;
  logic              done_s;
  logic              err_s;

  // Next-state decode plus completion / timeout strobes.
  always_comb begin
    state_next_s = state_r;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_ISSUE;
        else       state_next_s = ST_IDLE;
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (drdy_in) begin
          done_s       = 1'b1;
          state_next_s = ST_STORE;
        end else if (cnt_r == LAST_CNT) begin
          err_s        = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_STORE: begin
        if (start) state_next_s = ST_ISSUE;
        else       state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, registered DRP strobes, address latch and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      den_r   <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      den_r   <= (state_next_s == ST_ISSUE);
      busy_r  <= (state_next_s != ST_IDLE);
      if (state_r == ST_WAIT) cnt_r <= cnt_r + 10'd1;
      else                    cnt_r <= {CNT_W{1'b0}};
      // Address is only taken when a new transaction starts, so it stays
      // stable on the DRP bus through ISSUE and WAIT.
      if (start && ((state_r == ST_IDLE) || (state_r == ST_STORE))) addr_r <= addr;
    end
  end

  assign den   = den_r;
  assign daddr = addr_r;
  assign busy  = busy_r;
  assign done  = done_s;
  assign err   = err_s;
  assign state = state_r;

endmodule

// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler: shares the XADC DRP read port between an EOC-driven
// scan of NUM_CH auxiliary channels and a single on-demand host reader.
// Optional build macro: XADC_NOISE_MASK_EN zeroes the 4 LSBs of scan samples.
// Ports:
//   sysclk, rst_n                   100 MHz clock (also XADC dclk), async reset
//   eoc_in                          XADC end-of-conversion pulse
//   den_out, daddr_out              DRP enable / address to XADC
//   drdy_in, do_in                  DRP data ready / read data from XADC
//   host_req, host_addr             host read request (level) and address
//   host_ack, host_data, host_err   host completion pulse, data, timeout flag
//   sample_valid, sample_ch,
//   sample_data                     scan sample pulse, list index, 12-bit value
//   timeout_err                     pulse on any DRP timeout
//   busy                            transaction FSM not IDLE
module xadc_drp_scheduler
  import xadc_pkg::*;
#(
  parameter int                       NUM_CH   = 2,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDRS = {VAUX12_ADDR, VAUX4_ADDR},
  parameter int                       TIMEOUT  = 255
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                eoc_in,
  output logic                den_out,
  output logic [ADDR_W-1:0]   daddr_out,
  input  logic                drdy_in,
  input  logic [DATA_W-1:0]   do_in,
  input  logic                host_req,
  input  logic [ADDR_W-1:0]   host_addr,
  output logic                host_ack,
  output logic [DATA_W-1:0]   host_data,
  output logic                host_err,
  output logic                sample_valid,
  output logic [2:0]          sample_ch,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                timeout_err,
  output logic                busy
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

  drp_state_t          m_state_s;
  logic                m_done_s;
  logic                m_err_s;
  logic                start_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                grant_scan_s;
  logic                grant_host_s;
  logic                cont_s;
  logic                host_pend_s;
  logic [SAMPLE_W-1:0] sample_raw_s;

  logic                scan_pend_r;
  drp_src_t            last_grant_r;
  drp_src_t            cur_src_r;
  logic [2:0]          index_r;
  logic                host_ack_r;
  logic [DATA_W-1:0]   host_data_r;
  logic                host_err_r;
  logic                sample_valid_r;
  logic [2:0]          sample_ch_r;
  logic [SAMPLE_W-1:0] sample_data_r;
  logic                timeout_err_r;

  function automatic logic [ADDR_W-1:0] ch_addr(input logic [2:0] idx);
    int base;
    base = int'(idx) * ADDR_W;
    return CH_ADDRS[base +: ADDR_W];
  endfunction

`ifdef XADC_NOISE_MASK_EN
  assign sample_raw_s = do_in[DATA_W-1:4] & 12'hff0;
`else
  assign sample_raw_s = do_in[DATA_W-1:4];
`endif

  xadc_drp_master #(
    .TIMEOUT (TIMEOUT)
  ) u_master (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .start   (start_s),
    .addr    (addr_s),
    .drdy_in (drdy_in),
    .den     (den_out),
    .daddr   (daddr_out),
    .done    (m_done_s),
    .err     (m_err_s),
    .busy    (busy),
    .state   (m_state_s)
  );

  // Arbitration in IDLE and sweep continuation in STORE.
  always_comb begin
    // While host_ack is out the host has not yet had a chance to drop
    // host_req, so that level must not start a second read.
    host_pend_s  = host_req & ~host_ack_r;
    grant_scan_s = 1'b0;
    grant_host_s = 1'b0;
    cont_s       = 1'b0;
    start_s      = 1'b0;
    addr_s       = ch_addr(index_r);
    case (m_state_s)
      ST_IDLE: begin
        if (scan_pend_r && host_pend_s) begin
          if (last_grant_r == SRC_HOST) grant_scan_s = 1'b1;
          else                          grant_host_s = 1'b1;
        end else if (scan_pend_r) begin
          grant_scan_s = 1'b1;
        end else if (host_pend_s) begin
          grant_host_s = 1'b1;
        end else begin
          grant_scan_s = 1'b0;
        end
        start_s = grant_scan_s | grant_host_s;
        if (grant_host_s) addr_s = host_addr;
        else              addr_s = ch_addr(index_r);
      end
      ST_STORE: begin
        // A sweep keeps the port until its last channel has been stored.
        if ((cur_src_r == SRC_SCAN) && (index_r < LAST_IDX)) begin
          cont_s  = 1'b1;
          start_s = 1'b1;
          addr_s  = ch_addr(index_r + 3'd1);
        end else begin
          cont_s  = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Request bookkeeping, scan index and registered result outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_pend_r    <= 1'b0;
      last_grant_r   <= SRC_HOST;
      cur_src_r      <= SRC_HOST;
      index_r        <= 3'd0;
      host_ack_r     <= 1'b0;
      host_data_r    <= {DATA_W{1'b0}};
      host_err_r     <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_ch_r    <= 3'd0;
      sample_data_r  <= {SAMPLE_W{1'b0}};
      timeout_err_r  <= 1'b0;
    end else begin
      sample_valid_r <= 1'b0;
      host_ack_r     <= 1'b0;
      timeout_err_r  <= 1'b0;

      // A single pending flag: any number of EOCs during a sweep re-arm
      // exactly one more sweep. A new EOC wins over the grant clear.
      if (eoc_in)            scan_pend_r <= 1'b1;
      else if (grant_scan_s) scan_pend_r <= 1'b0;

      if (grant_scan_s)      cur_src_r <= SRC_SCAN;
      else if (grant_host_s) cur_src_r <= SRC_HOST;

      // Fairness history only moves on contended decisions, so an
      // uncontested grant does not steal the other side's next turn.
      if (grant_scan_s && host_pend_s)      last_grant_r <= SRC_SCAN;
      else if (grant_host_s && scan_pend_r) last_grant_r <= SRC_HOST;

      if (m_done_s) begin
        if (cur_src_r == SRC_SCAN) begin
          sample_valid_r <= 1'b1;
          sample_ch_r    <= index_r;
          sample_data_r  <= sample_raw_s;
        end else begin
          host_ack_r  <= 1'b1;
          host_data_r <= do_in;
          host_err_r  <= 1'b0;
        end
      end

      if (m_err_s) begin
        timeout_err_r <= 1'b1;
        if (cur_src_r == SRC_HOST) begin
          host_ack_r  <= 1'b1;
          host_err_r  <= 1'b1;
          host_data_r <= 16'hffff;
        end else begin
          index_r <= 3'd0;
        end
      end

      if ((m_state_s == ST_STORE) && (cur_src_r == SRC_SCAN)) begin
        if (cont_s) index_r <= index_r + 3'd1;
        else        index_r <= 3'd0;
      end
    end
  end

  assign host_ack     = host_ack_r;
  assign host_data    = host_data_r;
  assign host_err     = host_err_r;
  assign sample_valid = sample_valid_r;
  assign sample_ch    = sample_ch_r;
  assign sample_data  = sample_data_r;
  assign timeout_err  = timeout_err_r;

endmodule
